// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with a pixel-RAM read port.
//
// A horizontal/vertical counter pair walks the raster with hc=vc=0 at the
// first visible pixel. One register stage later the RAM address and read
// strobe are issued. The timing flags then travel through a RAM_LAT-deep
// shift register, so hsync/vsync/de/frame_start/vblank and the colours
// captured from pixel_in appear RAM_LAT+1 cycles after the counter state
// that produced them.
//
// Ports:
//   clk          pixel clock
//   clr          asynchronous active-high reset
//   en           run enable; en=0 synchronously clears counters and pipeline
//   test_mode    (VGA_TEST_PATTERN_EN only) colour-bar test pattern select
//   pixel_in     RAM read data, packed {r,g,b}
//   col_address  pixel RAM column (0 outside active video)
//   row_address  pixel RAM row    (0 outside active video)
//   rd           RAM read strobe
//   red/green/blue  pixel colour, 0 when de=0
//   hsync/vsync  sync outputs, active level HS_POL/VS_POL
//   de           data enable
//   frame_start  one-cycle pulse on the first pixel of a frame
//   vblank       vertical blanking flag
//
// Optional feature macro: VGA_TEST_PATTERN_EN adds test_mode and an
// 8-bar colour pattern; RAM reads are suppressed while it is selected.

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int RAM_LAT  = 1,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                     test_mode,
`endif
  input  logic [R_W+G_W+B_W-1:0]   pixel_in,
  output logic [COL_W-1:0]         col_address,
  output logic [ROW_W-1:0]         row_address,
  output logic                     rd,
  output logic [R_W-1:0]           red,
  output logic [G_W-1:0]           green,
  output logic [B_W-1:0]           blue,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic                     frame_start,
  output logic                     vblank
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W     = $clog2(H_TOTAL);
  localparam int VC_W     = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int PIX_W    = R_W + G_W + B_W;
  localparam logic HS_ON  = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON  = (VS_POL != 0) ? 1'b1 : 1'b0;

  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

  // Per-pixel flags carried down the delay pipeline. hs/vs hold the final
  // output levels so the last stage drives the pins directly.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vb;
`ifdef VGA_TEST_PATTERN_EN
    logic       tm;
    logic [2:0] bar;
`endif
  } flags_t;

`ifdef VGA_TEST_PATTERN_EN
  localparam int     BAR_W = H_ACTIVE / 8;
  localparam flags_t IDLE  = {1'b0, ~HS_ON, ~VS_ON, 2'b00, 4'b0000};
`else
  localparam flags_t IDLE  = {1'b0, ~HS_ON, ~VS_ON, 2'b00};
`endif

  logic [HC_W-1:0]  hc;
  logic [VC_W-1:0]  vc;
  logic [31:0]      hc_u;
  logic [31:0]      vc_u;
  logic             active;
  logic             rd_nxt;
  flags_t           nxt;
  flags_t           stg [RAM_LAT+1];  // stg[0]: address stage, stg[RAM_LAT]: outputs
  logic [PIX_W-1:0] pix_nxt;
  logic [PIX_W-1:0] pix_q;

  always_comb begin
    hc_u   = 32'(hc);
    vc_u   = 32'(vc);
    active = (hc_u < H_ACTIVE) && (vc_u < V_ACTIVE);
    nxt    = IDLE;
    nxt.de = active;
    nxt.hs = (hc_u >= HS_START && hc_u < HS_END) ? HS_ON : ~HS_ON;
    nxt.vs = (vc_u >= VS_START && vc_u < VS_END) ? VS_ON : ~VS_ON;
    nxt.fs = (hc_u == 0) && (vc_u == 0);
    nxt.vb = (vc_u >= V_ACTIVE);
    rd_nxt = active;
`ifdef VGA_TEST_PATTERN_EN
    nxt.tm  = test_mode;
    nxt.bar = 3'(hc_u / 32'(BAR_W));
    rd_nxt  = active & ~test_mode;
`endif
  end

  // Colour capture uses the flags one stage before the output so that the
  // colour register and the output flags load on the same edge.
  always_comb begin
    pix_nxt = stg[RAM_LAT-1].de ? pixel_in : '0;
`ifdef VGA_TEST_PATTERN_EN
    if (stg[RAM_LAT-1].tm) begin
      pix_nxt = stg[RAM_LAT-1].de
              ? {{R_W{stg[RAM_LAT-1].bar[2]}},
                 {G_W{stg[RAM_LAT-1].bar[1]}},
                 {B_W{stg[RAM_LAT-1].bar[0]}}}
              : '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hc          <= '0;
      vc          <= '0;
      rd          <= 1'b0;
      col_address <= '0;
      row_address <= '0;
      pix_q       <= '0;
      for (int unsigned i = 0; i < RAM_LAT + 1; i++) stg[i] <= IDLE;
    end else if (!en) begin
      hc          <= '0;
      vc          <= '0;
      rd          <= 1'b0;
      col_address <= '0;
      row_address <= '0;
      pix_q       <= '0;
      for (int unsigned i = 0; i < RAM_LAT + 1; i++) stg[i] <= IDLE;
    end else begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
      rd          <= rd_nxt;
      col_address <= active ? COL_W'(hc) : '0;
      row_address <= active ? ROW_W'(vc) : '0;
      stg[0]      <= nxt;
      for (int unsigned i = 1; i < RAM_LAT + 1; i++) stg[i] <= stg[i-1];
      pix_q       <= pix_nxt;
    end
  end

  assign de          = stg[RAM_LAT].de;
  assign hsync       = stg[RAM_LAT].hs;
  assign vsync       = stg[RAM_LAT].vs;
  assign frame_start = stg[RAM_LAT].fs;
  assign vblank      = stg[RAM_LAT].vb;
  assign red         = pix_q[PIX_W-1 -: R_W];
  assign green       = pix_q[G_W+B_W-1 -: G_W];
  assign blue        = pix_q[B_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster (24x14,
// RAM_LAT=3, active-high vsync) with a behavioural raster model computed
// from the pixel position, plus directed checks of frame counts, enable
// drop and reset recovery.

module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 3;
  localparam int CW = 5, RW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic          tm;
  logic [7:0]    pixel_in;
  logic [CW-1:0] col_address;
  logic [RW-1:0] row_address;
  logic          rd;
  logic [2:0]    red;
  logic [2:0]    green;
  logic [1:0]    blue;
  logic          hsync, vsync, de, frame_start, vblank;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(1), .RAM_LAT(LAT),
    .R_W(3), .G_W(3), .B_W(2), .COL_W(CW), .ROW_W(RW)
  ) dut (
    .clk(clk), .clr(clr), .en(en),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .pixel_in(pixel_in), .col_address(col_address), .row_address(row_address),
    .rd(rd), .red(red), .green(green), .blue(blue), .hsync(hsync),
    .vsync(vsync), .de(de), .frame_start(frame_start), .vblank(vblank)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] ram_f(input logic [4:0] c, input logic [3:0] r);
    return {c[2:0], r[2:0], c[4:3]};
  endfunction

  // Pixel RAM: data for an address is presented LAT-1 cycles after it is
  // registered, so it is captured LAT edges after the rd launch edge.
  logic [CW+RW-1:0] dly [LAT-1];
  always @(posedge clk) begin
    dly[0] <= {col_address, row_address};
    for (int k = 1; k < LAT - 1; k++) dly[k] <= dly[k-1];
  end
  assign pixel_in = ram_f(dly[LAT-2][CW+RW-1:RW], dly[LAT-2][RW-1:0]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       rd;
    logic [4:0] col;
    logic [3:0] row;
    logic       de, hs, vs, fs, vb;
    logic [7:0] pix;
  } rec_t;

  function automatic rec_t idle_rec();
    rec_t r;
    r.rd = 0; r.col = 0; r.row = 0; r.de = 0; r.hs = 1; r.vs = 0;
    r.fs = 0; r.vb = 0; r.pix = 0;
    return r;
  endfunction

  function automatic rec_t expect_at(input int p, input logic t);
    rec_t r;
    int h, v;
    logic act;
    logic [2:0] bar;
    h = p % HT;
    v = p / HT;
    act = (h < HA) && (v < VA);
    bar = 3'(h / (HA / 8));
    r.rd  = act && !t;
    r.col = act ? 5'(h) : 5'd0;
    r.row = act ? 4'(v) : 4'd0;
    r.de  = act;
    r.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    r.vs  = (v >= VA + VF) && (v < VA + VF + VS);
    r.fs  = (p == 0);
    r.vb  = (v >= VA);
    r.pix = !act ? 8'h00
          : t ? {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}}
          : ram_f(5'(h), 4'(v));
    return r;
  endfunction

  // Raster model: hist[0] is the address-stage view of the latest counter
  // position, hist[LAT] the pixel currently due at the outputs.
  rec_t hist [LAT+1];
  int   pos = 0;
  bit   chk_on = 0;

  initial forever begin
    @(posedge clk);
    if (clr || !en) begin
      for (int k = 0; k <= LAT; k++) hist[k] = idle_rec();
      pos = 0;
    end else begin
      for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = expect_at(pos, tm);
      pos = (pos + 1) % FRAME;
    end
    #1;
    if (chk_on) begin
      check("rd",    rd,          hist[0].rd);
      check("col",   col_address, hist[0].col);
      check("row",   row_address, hist[0].row);
      check("de",    de,          hist[LAT].de);
      check("hsync", hsync,       hist[LAT].hs);
      check("vsync", vsync,       hist[LAT].vs);
      check("fs",    frame_start, hist[LAT].fs);
      check("vblank", vblank,     hist[LAT].vb);
      check("red",   red,         hist[LAT].pix[7:5]);
      check("green", green,       hist[LAT].pix[4:2]);
      check("blue",  blue,        hist[LAT].pix[1:0]);
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_rd"},  rd, 0);
    check({tag, "_de"},  de, 0);
    check({tag, "_fs"},  frame_start, 0);
    check({tag, "_vb"},  vblank, 0);
    check({tag, "_hs"},  hsync, 1);
    check({tag, "_vs"},  vsync, 0);
    check({tag, "_rgb"}, {red, green, blue}, 0);
    check({tag, "_adr"}, {col_address, row_address}, 0);
  endtask

  // Counts negedges until frame_start is seen; returns limit on timeout.
  task automatic wait_fs(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
    end
  endtask

  int n, cyc, de_c, hs_c, vs_c, r;

  initial begin
    clr = 1'b0; en = 1'b0; tm = 1'b0;
    #2 clr = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1;
    check_idle("rst");
    clr = 1'b0; en = 1'b1;

    // first frame_start after reset release
    wait_fs(FRAME + 10, n);
    check("fs_after_rst", n, LAT + 1);

    // one full frame: period and per-frame counts
    cyc = 0; de_c = 0; hs_c = 0; vs_c = 0;
    do begin
      de_c += int'(de);
      hs_c += int'(!hsync);
      vs_c += int'(vsync);
      @(negedge clk);
      cyc++;
    end while (!frame_start && cyc < FRAME + 10);
    check("fs_period", cyc, FRAME);
    check("de_frame",  de_c, HA * VA);
    check("hs_frame",  hs_c, HS * VT);
    check("vs_frame",  vs_c, VS * HT);

    // en drop mid-line mid-frame
    n = 0;
    while (pos != 5 * HT + 7 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("pos_reached", pos, 5 * HT + 7);
    en = 1'b0;
    @(negedge clk);
    check_idle("en_off");
    repeat (9) @(negedge clk);
    en = 1'b1;
    wait_fs(FRAME + 10, n);
    check("fs_after_en", n, LAT + 1);

    // asynchronous clear mid-frame
    repeat (100) @(negedge clk);
    clr = 1'b1;
    #1 check_idle("clr_async");
    repeat (2) @(negedge clk);
    clr = 1'b0;
    wait_fs(FRAME + 10, n);
    check("fs_after_clr", n, LAT + 1);

    // randomized disturbances; the raster model checks every cycle
    repeat (3000) begin
      @(negedge clk);
      r = int'($urandom_range(0, 999));
      if (r < 4) begin
        en = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clk);
        en = 1'b1;
      end else if (r < 6) begin
        clr = 1'b1;
        #1 check_idle("clr_rand");
        repeat ($urandom_range(1, 3)) @(negedge clk);
        clr = 1'b0;
      end
`ifdef VGA_TEST_PATTERN_EN
      else if (r < 10) begin
        tm = ~tm;
      end
`endif
    end

`ifdef VGA_TEST_PATTERN_EN
    tm = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    tm = 1'b0;
`endif

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync pulse width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch.
- HS_POL, 0, hsync active level.
- VS_POL, 0, vsync active level.
- RAM_LAT, 1, pixel RAM read latency in cycles (1..4).
- R_W, 3, red width.
- G_W, 3, green width.
- B_W, 2, blue width.
- COL_W, 10, column address width.
- ROW_W, 9, row address width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, pixel clock.
- clr, in, 1, asynchronous active-high reset.
- en, in, 1, timing run enable.
- pixel_in, in, R_W+G_W+B_W, RAM data packed {r,g,b}.
- col_address, out, COL_W, pixel RAM column.
- row_address, out, ROW_W, pixel RAM row.
- rd, out, 1, RAM read strobe.
- red, out, R_W, red.
- green, out, G_W, green.
- blue, out, B_W, blue.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- de, out, 1, data enable.
- frame_start, out, 1, one-cycle frame pulse.
- vblank, out, 1, vertical blanking flag.

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; counters hc, vc start at 0 on the first active pixel.
REQ-004 Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; same order vertically.
REQ-005 hc increments every cycle while en=1 and wraps H_TOTAL-1 -> 0; vc increments on hc wrap and wraps V_TOTAL-1 -> 0.
REQ-006 en=0 clears hc and vc to 0 synchronously and forces all outputs to their reset values; counting restarts at hc=vc=0 on the first cycle en=1.
REQ-007 Stage 0 (registered one cycle after the counter state): rd=1 only when hc<H_ACTIVE and vc<V_ACTIVE, with col_address=hc and row_address=vc; otherwise col_address=0 and row_address=0.
REQ-008 pixel_in is sampled exactly RAM_LAT cycles after the rd for the same address.
REQ-009 red, green, blue, hsync, vsync, de, frame_start and vblank are registered and aligned to the same pixel: total latency from counter state to these outputs is RAM_LAT+1 cycles.
REQ-010 de mirrors the delayed rd; red, green and blue are 0 whenever de=0.
REQ-011 hsync = HS_POL inside the horizontal sync window, else ~HS_POL; vsync = VS_POL inside the vertical sync window for the whole line, else ~VS_POL.
REQ-012 frame_start=1 for one cycle at the delayed state hc=0,vc=0; vblank=1 at the delayed state vc>=V_ACTIVE.
REQ-013 The delay pipeline is a shift register of depth RAM_LAT; no other buffering is used.

Reset
REQ-014 clr=1 asynchronously clears hc, vc and the pipeline.
REQ-015 While clr=1: rd, de, frame_start and vblank are 0; red, green, blue and both addresses are 0; hsync=~HS_POL; vsync=~VS_POL.
REQ-016 Reset asserted mid-line aborts the line; after release the first output pixel is hc=vc=0, delivered RAM_LAT+1 cycles later.

Configuration
REQ-017 Macro VGA_TEST_PATTERN_EN defined:
- Adds input test_mode (1 bit).
- While test_mode=1: rd is held 0, and during active video colors show 8 vertical bars; bar index i = hc/(H_ACTIVE/8) in 0..7; red is all-ones if i[2], green if i[1], blue if i[0]; timing and latency are unchanged.
REQ-018 Macro undefined: test_mode port and pattern logic are absent; behaviour is per REQ-003..016.

Verification
REQ-019 Defaults, en=1, after reset -> frame_start period 420000 cycles; hsync low for 96 cycles per 800.
REQ-020 Defaults -> de high 640 cycles per line and 307200 cycles per frame; vsync low exactly 1600 cycles starting at vc=490.
REQ-021 RAM_LAT=3, pixel_in model returns {col[2:0],row[2:0],col[4:3]} -> red/green/blue match the model's value for each de pixel, with de rising 4 cycles after hc=0.
REQ-022 en dropped at hc=300,vc=200 for 10 cycles -> outputs idle within 1 cycle, hsync and vsync inactive; next frame_start 4 cycles after en returns with RAM_LAT=3.
REQ-023 clr pulsed mid-frame -> immediate reset values; next frame_start RAM_LAT+1 cycles after release.
REQ-024 VGA_TEST_PATTERN_EN, test_mode=1 -> pixels 0..79 are black, pixels 560..639 are all-ones (white), rd stays 0.
